// File: rtl/dmem_if.sv
// Request/response channel pair between the core's MEM stage and its data memory.
// The master modport is the core side, the slave modport is the memory side.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, a fixed number of
// wait states, then a single access cycle and a held response with error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] ADDR_BASE   = 32'h10010000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    dmem_if.slave   bus,
    output logic    busy
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          acc_err;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic          mem_we;

    // Offset wraps in 32 bits, so addresses below the base land far out of range.
    assign offset   = addr_q - ADDR_BASE;
    assign word_idx = offset[AW+1:2];
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign rd_half  = rd_word[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        acc_err   = (offset >= SPAN);
        load_data = rd_word;
        wr_data   = wdata_q;
        wr_be     = 4'hF;
        case (size_q)
            2'b00: begin
                load_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                wr_data   = {4{wdata_q[7:0]}};
                wr_be     = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                if (addr_q[0]) begin
                    acc_err = 1'b1;
                end
                load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                wr_data   = {2{wdata_q[15:0]}};
                wr_be     = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                if (addr_q[1:0] != 2'b00) begin
                    acc_err = 1'b1;
                end
            end
            default: begin
                acc_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
                mem_we      = we_q && !acc_err;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Contents survive reset; a write only fires from ACCESS, which reset leaves at once.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic against a
// byte-mask memory model; a second instance covers the zero-wait-state build.
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h10010000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_if bus_a ();
    dmem_if bus_b ();
    logic busy_a, busy_b;

    dmem_responder #(.DEPTH(256), .ADDR_BASE(BASE), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .busy(busy_a)
    );
    dmem_responder #(.DEPTH(256), .ADDR_BASE(BASE), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .busy(busy_b)
    );

    // Index 0 drives dut_a, index 1 drives dut_b.
    logic [1:0]  req_valid_t, req_we_t, req_uns_t, rsp_ready_t;
    logic [31:0] req_addr_t [2];
    logic [31:0] req_wdata_t [2];
    logic [1:0]  req_size_t [2];
    logic [1:0]  req_ready_o, rsp_valid_o, rsp_err_o, busy_o;
    logic [31:0] rsp_rdata_o [2];

    assign bus_a.req_valid    = req_valid_t[0];
    assign bus_a.req_we       = req_we_t[0];
    assign bus_a.req_addr     = req_addr_t[0];
    assign bus_a.req_wdata    = req_wdata_t[0];
    assign bus_a.req_size     = req_size_t[0];
    assign bus_a.req_unsigned = req_uns_t[0];
    assign bus_a.rsp_ready    = rsp_ready_t[0];
    assign bus_b.req_valid    = req_valid_t[1];
    assign bus_b.req_we       = req_we_t[1];
    assign bus_b.req_addr     = req_addr_t[1];
    assign bus_b.req_wdata    = req_wdata_t[1];
    assign bus_b.req_size     = req_size_t[1];
    assign bus_b.req_unsigned = req_uns_t[1];
    assign bus_b.rsp_ready    = rsp_ready_t[1];

    assign req_ready_o[0] = bus_a.req_ready;
    assign req_ready_o[1] = bus_b.req_ready;
    assign rsp_valid_o[0] = bus_a.rsp_valid;
    assign rsp_valid_o[1] = bus_b.rsp_valid;
    assign rsp_err_o[0]   = bus_a.rsp_err;
    assign rsp_err_o[1]   = bus_b.rsp_err;
    assign rsp_rdata_o[0] = bus_a.rsp_rdata;
    assign rsp_rdata_o[1] = bus_b.rsp_rdata;
    assign busy_o[0]      = busy_a;
    assign busy_o[1]      = busy_b;

    logic [31:0] model_mem [16];

    // One full transaction with rsp_ready held high. acc is the cycle count just
    // after the accepting edge; lat is how many further edges until rsp_valid is seen.
    task automatic txn(input int s, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic err,
                       output int acc, output int lat);
        int n;
        req_we_t[s]    = we;
        req_addr_t[s]  = addr;
        req_wdata_t[s] = wdata;
        req_size_t[s]  = size;
        req_uns_t[s]   = uns;
        req_valid_t[s] = 1'b1;
        rsp_ready_t[s] = 1'b1;
        n = 0;
        while (!req_ready_o[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", s, req_ready_o[s]);
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        req_valid_t[s] = 1'b0;
        n = 0;
        while (!rsp_valid_o[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1", s, rsp_valid_o[s]);
        end
        lat   = cyc - acc;
        rdata = rsp_rdata_o[s];
        err   = rsp_err_o[s];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic er;
        int acc, lat;
        n_checks += 5;
        if (busy_o[0] !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy_o[0]); end
        if (req_ready_o[0] !== 1'b1)     begin n_fail++; $display("FAIL rst_req_ready: got %b required 1", req_ready_o[0]); end
        if (rsp_valid_o[0] !== 1'b0)     begin n_fail++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid_o[0]); end
        if (rsp_rdata_o[0] !== 32'h0)    begin n_fail++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata_o[0]); end
        if (rsp_err_o[0] !== 1'b0)       begin n_fail++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err_o[0]); end
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b1, BASE, 32'h11111111, 2'b10, 1'b0, rd, er, acc, lat);
        // Start a store, then reset it while it sits in its wait states.
        req_we_t[0] = 1'b1; req_addr_t[0] = BASE; req_wdata_t[0] = 32'hAAAAAAAA;
        req_size_t[0] = 2'b10; req_uns_t[0] = 1'b0; req_valid_t[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_t[0] = 1'b0;
        n_checks++;
        if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b required 1", busy_o[0]); end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (busy_o[0] !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy_o[0]); end
        if (req_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready: got %b required 1", req_ready_o[0]); end
        if (rsp_valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b required 0", rsp_valid_o[0]); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, BASE, 32'h0, 2'b10, 1'b0, rd, er, acc, lat);
        n_checks += 2;
        if (rd !== 32'h11111111) begin n_fail++; $display("FAIL store_aborted: got %h required 11111111", rd); end
        if (er !== 1'b0)         begin n_fail++; $display("FAIL store_aborted_err: got %b required 0", er); end
        $display("test_reset: load after aborted store rdata=%h", rd);
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic er;
        int acc, lat;
        // WAIT_CYCLES=2: rsp_valid in the cycle closed by edge N+4, i.e. 3 edges after accept.
        txn(0, 1'b1, BASE + 32'd8, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, acc, lat);
        n_checks += 3;
        if (er !== 1'b0)   begin n_fail++; $display("FAIL word_st_err: got %b required 0", er); end
        if (rd !== 32'h0)  begin n_fail++; $display("FAIL word_st_rdata: got %h required 0", rd); end
        if (lat != 3)      begin n_fail++; $display("FAIL word_st_latency: got %0d required 3", lat); end
        txn(0, 1'b0, BASE + 32'd8, 32'h0, 2'b10, 1'b0, rd, er, acc, lat);
        n_checks += 3;
        if (er !== 1'b0)          begin n_fail++; $display("FAIL word_ld_err: got %b required 0", er); end
        if (rd !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL word_ld_rdata: got %h required deadbeef", rd); end
        if (lat != 3)             begin n_fail++; $display("FAIL word_ld_latency: got %0d required 3", lat); end
        $display("test_word: load rdata=%h latency=%0d", rd, lat);
    endtask

    task automatic test_lanes();
        logic        we_v  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] off_v [6] = '{32'd9, 32'd9, 32'd9, 32'd8, 32'd10, 32'd8};
        logic [31:0] wd_v  [6] = '{32'h80, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0};
        logic [1:0]  sz_v  [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        logic        un_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] ex_v  [6] = '{32'h0, 32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF, 32'h0, 32'h123480EF};
        logic [31:0] rd;
        logic er;
        int acc, lat;
        for (int i = 0; i < 6; i++) begin
            txn(0, we_v[i], BASE + off_v[i], wd_v[i], sz_v[i], un_v[i], rd, er, acc, lat);
            n_checks += 2;
            if (rd !== ex_v[i]) begin n_fail++; $display("FAIL lanes_%0d_rdata: got %h required %h", i, rd, ex_v[i]); end
            if (er !== 1'b0)    begin n_fail++; $display("FAIL lanes_%0d_err: got %b required 0", i, er); end
            $display("test_lanes[%0d]: we=%b off=%0d size=%b rdata=%h", i, we_v[i], off_v[i], sz_v[i], rd);
        end
    endtask

    task automatic test_errors();
        logic        we_v  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] off_v [7] = '{32'd1, 32'd1024, 32'd0, 32'd4, 32'd2, 32'd0, 32'hFFFFFFFC};
        logic [31:0] wd_v  [7] = '{32'h0, 32'h55555555, 32'h0, 32'h0, 32'h66666666, 32'h0, 32'h0};
        logic [1:0]  sz_v  [7] = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10};
        logic        ee_v  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] ex_v  [7] = '{32'h0, 32'h0, 32'h11111111, 32'h0, 32'h0, 32'h11111111, 32'h0};
        logic [31:0] rd;
        logic er;
        int acc, lat;
        for (int i = 0; i < 7; i++) begin
            txn(0, we_v[i], BASE + off_v[i], wd_v[i], sz_v[i], 1'b0, rd, er, acc, lat);
            n_checks += 2;
            if (er !== ee_v[i]) begin n_fail++; $display("FAIL err_%0d_flag: got %b required %b", i, er, ee_v[i]); end
            if (rd !== ex_v[i]) begin n_fail++; $display("FAIL err_%0d_rdata: got %h required %h", i, rd, ex_v[i]); end
            $display("test_errors[%0d]: addr=%h size=%b err=%b rdata=%h", i, BASE + off_v[i], sz_v[i], er, rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int n;
        rsp_ready_t[0] = 1'b0;
        req_we_t[0] = 1'b0; req_addr_t[0] = BASE + 32'd8; req_size_t[0] = 2'b10;
        req_uns_t[0] = 1'b0; req_valid_t[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_t[0] = 1'b0;
        n = 0;
        while (!rsp_valid_o[0] && n < 50) begin @(negedge clk); n++; end
        held = rsp_rdata_o[0];
        n_checks++;
        if (held !== 32'h123480EF) begin n_fail++; $display("FAIL bp_rdata: got %h required 123480ef", held); end
        // A second request waits on the bus while the response is stalled.
        req_addr_t[0] = BASE; req_valid_t[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks += 3;
            if (rsp_valid_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b required 1", i, rsp_valid_o[0]); end
            if (rsp_rdata_o[0] !== held) begin n_fail++; $display("FAIL bp_stable_%0d: got %h required %h", i, rsp_rdata_o[0], held); end
            if (req_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready_%0d: got %b required 0", i, req_ready_o[0]); end
            @(negedge clk);
        end
        rsp_ready_t[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 2;
        if (req_ready_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", req_ready_o[0]); end
        if (busy_o[0] !== 1'b0)      begin n_fail++; $display("FAIL bp_release_busy: got %b required 0", busy_o[0]); end
        @(posedge clk);
        @(negedge clk);
        req_valid_t[0] = 1'b0;
        n_checks++;
        if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_second_accept: got %b required 1", busy_o[0]); end
        n = 0;
        while (!rsp_valid_o[0] && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (rsp_rdata_o[0] !== 32'h11111111) begin n_fail++; $display("FAIL bp_second_rdata: got %h required 11111111", rsp_rdata_o[0]); end
        $display("test_backpressure: held=%h second=%h", held, rsp_rdata_o[0]);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, off, mask, exp_d, v;
        logic [1:0] size;
        logic er, we, uns, exp_e;
        int acc, lat, r, sh, nb;
        for (int w = 0; w < 16; w++) begin
            model_mem[w] = $urandom;
            txn(0, 1'b1, BASE + 32'(4 * w), model_mem[w], 2'b10, 1'b0, rd, er, acc, lat);
        end
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = BASE + 32'd1024 + ($urandom % 64);
            else if (r == 1) addr = BASE - 32'd1 - ($urandom % 8);
            else             addr = BASE + ($urandom % 64);
            r = $urandom_range(0, 7);
            size  = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            we    = 1'($urandom % 2);
            uns   = 1'($urandom % 2);
            wdata = $urandom;
            off   = addr - BASE;
            exp_e = (off >= 32'd1024) || (size == 2'b11) ||
                    (size == 2'b01 && addr % 2 != 0) || (size == 2'b10 && addr % 4 != 0);
            exp_d = 32'h0;
            if (!exp_e) begin
                nb   = 1 << size;
                mask = (nb == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * nb)) - 32'h1);
                sh   = 8 * int'(addr % 4);
                if (we) begin
                    model_mem[off / 4] = (model_mem[off / 4] & ~(mask << sh)) | ((wdata & mask) << sh);
                end else begin
                    v = (model_mem[off / 4] >> sh) & mask;
                    if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 32'h1) != 0) v = v | ~mask;
                    exp_d = v;
                end
            end
            txn(0, we, addr, wdata, size, uns, rd, er, acc, lat);
            n_checks += 3;
            if (er !== exp_e) begin n_fail++; $display("FAIL rand_%0d_err: got %b required %b", i, er, exp_e); end
            if (rd !== exp_d) begin n_fail++; $display("FAIL rand_%0d_rdata: got %h required %h", i, rd, exp_d); end
            if (lat != 3)     begin n_fail++; $display("FAIL rand_%0d_latency: got %0d required 3", i, lat); end
            $display("test_random[%0d]: we=%b addr=%h size=%b uns=%b err=%b rdata=%h", i, we, addr, size, uns, er, rd);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] off_v [4] = '{32'd4, 32'd4, 32'd7, 32'd6};
        logic [1:0]  sz_v  [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
        logic [31:0] ex_v  [4] = '{32'hCAFEF00D, 32'hCAFEF00D, 32'hFFFFFFCA, 32'hFFFFCAFE};
        logic [31:0] rd;
        logic er;
        int acc, lat, acc_prev;
        txn(1, 1'b1, BASE + 32'd4, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, acc, lat);
        n_checks++;
        if (lat != 1) begin n_fail++; $display("FAIL w0_store_latency: got %0d required 1", lat); end
        acc_prev = acc;
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0, BASE + off_v[i], 32'h0, sz_v[i], 1'b0, rd, er, acc, lat);
            n_checks += 4;
            if (rd !== ex_v[i])        begin n_fail++; $display("FAIL w0_%0d_rdata: got %h required %h", i, rd, ex_v[i]); end
            if (er !== 1'b0)           begin n_fail++; $display("FAIL w0_%0d_err: got %b required 0", i, er); end
            if (lat != 1)              begin n_fail++; $display("FAIL w0_%0d_latency: got %0d required 1", i, lat); end
            if (acc - acc_prev != 3)   begin n_fail++; $display("FAIL w0_%0d_spacing: got %0d required 3", i, acc - acc_prev); end
            $display("test_wait0[%0d]: rdata=%h latency=%0d spacing=%0d", i, rd, lat, acc - acc_prev);
            acc_prev = acc;
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid_t[s] = 1'b0;
            req_we_t[s]    = 1'b0;
            req_uns_t[s]   = 1'b0;
            rsp_ready_t[s] = 1'b1;
            req_addr_t[s]  = 32'h0;
            req_wdata_t[s] = 32'h0;
            req_size_t[s]  = 2'b00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_random();
        test_wait0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32 core.
- Accepts load/store requests from the core's MEM stage over a valid/ready handshake.
- Inserts a configurable number of wait states, then commits the store or performs the load.
- Returns the result on a separate valid/ready response channel.
- Replaces the single-cycle DMEM so the core can be tested against realistic memory latency and fault reporting.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two.
- ADDR_BASE, 32'h10010000, byte address of word 0.
- WAIT_CYCLES, 2, wait states between request acceptance and memory access; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bytes are used for byte/half stores.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or illegal-size access.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, wait counter=0.
- Memory array contents are not reset.
- Reset asserted mid-operation aborts the transaction. A store not yet committed is never written.
- Request capture: a handshake occurs when req_valid && req_ready at a rising edge. Address, we, wdata, size and unsigned are registered.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On handshake, go to WAIT with counter=WAIT_CYCLES-1, or go directly to ACCESS if WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; go to ACCESS when the counter is 0.
- ACCESS (one cycle):
  - Compute offset = addr - ADDR_BASE (32-bit unsigned wrap).
  - Error if offset >= DEPTH*4, or size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - On error: no memory write, rsp_err=1, rsp_rdata=0.
  - Otherwise word index = offset[log2(DEPTH)+1:2], little-endian byte lanes selected by addr[1:0].
  - Store: writes only the addressed byte(s) from wdata[7:0], [15:0] or [31:0]; other bytes are unchanged.
  - Load: extracts byte/half/word and sign- or zero-extends per req_unsigned.
  - Load/store result is registered into rsp_rdata/rsp_err; go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
  - On that edge go to IDLE and clear rsp_valid.
  - req_ready stays 0 during RESP, so at most one transaction is outstanding.
- Latency: a request accepted at edge N gives rsp_valid high in cycle N+WAIT_CYCLES+2 when rsp_ready is held high. With WAIT_CYCLES=2, response is visible 4 cycles after acceptance. Sustained throughput is one transaction per WAIT_CYCLES+3 cycles.
- Simultaneous events: rsp_ready high outside RESP is ignored. req_valid outside IDLE is ignored and is not queued.
- Read-after-write: a load following a store to the same word returns the newly stored data.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT of a store to ADDR_BASE, release, then load word ADDR_BASE -> rsp_valid=0 after reset, store not committed, busy=0, req_ready=1.
- Word store/load: store 32'hDEADBEEF at ADDR_BASE+8, then load word -> rsp_rdata=32'hDEADBEEF, rsp_err=0; rsp_valid rises exactly 4 cycles after each accept (WAIT_CYCLES=2).
- Byte/half lanes: store byte 8'h80 at ADDR_BASE+9, then:
  - load signed byte -> 32'hFFFFFF80.
  - load unsigned byte -> 32'h00000080.
  - load word at +8 -> 32'hDEAD80EF.
  - store half 16'h1234 at +10, load word -> 32'h123480EF.
- Errors:
  - load half at ADDR_BASE+1 -> rsp_err=1, rsp_rdata=0.
  - store word at ADDR_BASE+1024 (DEPTH=256) -> rsp_err=1, and a word load at ADDR_BASE confirms memory unchanged.
  - size=11 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable; req_valid asserted meanwhile is not accepted (req_ready=0); accepted only after the response handshake.
- WAIT_CYCLES=0 build: back-to-back loads with rsp_ready=1 -> response 2 cycles after accept, new accept every 3 cycles.
